shift_reg_ctrl: RTL
===================

SHIFT_REG_CTRL -- requirements
Module: shift_reg_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, register width in bits (>=2).
REQ-002 SHALL have parameter AMT_W, default 3, width of the shift-amount field.
REQ-003 SHALL have port clock  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset is synchronous and active-high.
REQ-005 SHALL have port in  input  1  serial data bit inserted by LSL/LSR steps.
REQ-006 SHALL have port start  input  1  operation request, sampled only in IDLE.
REQ-007 SHALL have port op  input  3  operation code, latched on accepted start.
REQ-008 SHALL have port amt  input  AMT_W  number of single-bit steps, latched on accepted start.
REQ-009 SHALL have port load_data  input  WIDTH  parallel load value.
REQ-010 SHALL have port out  output  WIDTH  register contents.
REQ-011 SHALL have port sout  output  1  last bit shifted or rotated out of the register.
REQ-012 SHALL have port busy  output  1  high in RUN and DONE states.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-014 SHALL implement FSM states IDLE, RUN and DONE, with busy = (state != IDLE) and done = (state == DONE).
REQ-015 SHALL accept start only in IDLE; start in RUN or DONE is ignored, with no queueing.
REQ-016 SHALL decode op codes: 0 LSL (in enters bit 0), 1 LSR (in enters MSB), 2 ROL, 3 ROR, 4 ASR (MSB replicated), 5 LOAD, 6/7 NOP.
REQ-017 On accepted start with a shift/rotate op and amt>0, SHALL latch op, set count=amt, go to RUN, and leave out unchanged on that edge.
REQ-018 In RUN, SHALL perform exactly one single-bit step per rising edge and decrement count; the edge that performs the step with count==1 SHALL move the FSM to DONE.
REQ-019 SHALL sample in on each RUN edge, not at start.
REQ-020 Per step, SHALL update sout as: LSL/ROL take the old MSB; LSR/ROR/ASR take the old bit 0.
REQ-021 On accepted start with LOAD, SHALL write out<=load_data on the start edge, go directly to DONE, and leave sout unchanged.
REQ-022 On accepted start with NOP, or with any shift/rotate op and amt==0, SHALL go directly to DONE and leave out and sout unchanged.
REQ-023 DONE SHALL last exactly one cycle, then return to IDLE; total latency from the start edge to done high is amt+1 edges for shifts and 1 edge for LOAD/NOP/amt==0.
REQ-024 SHALL not clamp amt: amt > WIDTH performs amt steps, so rotates wrap and LSL/LSR flush the register completely.
REQ-025 SHALL hold out and sout in IDLE and DONE.

Reset
REQ-026 On a rising edge with reset=1, SHALL set out=0, sout=0, count=0 and state=IDLE (busy=0, done=0), overriding any operation in progress and any start.
REQ-027 After reset deasserts, SHALL accept start on the first edge that has reset=0.

Verification
REQ-028 Reset: assert reset for 1 edge from arbitrary state -> out=0000, sout=0, busy=0, done=0.
REQ-029 LOAD: start, op=5, load_data=1011 -> out=1011 after edge 1; done high for exactly one cycle; busy high only that cycle.
REQ-030 ROL: from out=1011, start op=2 amt=2 -> 0111 (sout=1), then 1110 (sout=0); done after the second step.
REQ-031 LSL serial: from 0000, op=0 amt=4, in=1,0,1,1 on the RUN edges -> 0001, 0010, 0101, 1011; done one cycle.
REQ-032 ASR/LSR: from 1000, ASR amt=3 -> 1111, sout=0; from 1000, LSR amt=7 with in=0 -> 0000 (wrap, no clamp).
REQ-033 Robustness: start pulsed during RUN and DONE -> ignored; reset asserted mid-RUN -> out=0 and IDLE on the next edge, with no done pulse.

Source files
------------

// File: rtl/shift_reg_ctrl.sv
// Sequenced shift/rotate register: one start request runs amt single-bit
// steps of the latched op, or a one-edge parallel load, then pulses done.
module shift_reg_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned AMT_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] out,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_LSL  = 3'd0;
  localparam logic [2:0] OP_LSR  = 3'd1;
  localparam logic [2:0] OP_ROL  = 3'd2;
  localparam logic [2:0] OP_ROR  = 3'd3;
  localparam logic [2:0] OP_ASR  = 3'd4;
  localparam logic [2:0] OP_LOAD = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [2:0]         r_op;
  logic [2:0]         w_op_nxt;
  logic [AMT_W-1:0]   r_count;
  logic [AMT_W-1:0]   w_count_nxt;
  logic [WIDTH-1:0]   r_out;
  logic [WIDTH-1:0]   w_out_nxt;
  logic               r_sout;
  logic               w_sout_nxt;
  logic               r_busy;
  logic               r_done;

  // State, datapath and status registers; busy/done registered from next state
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_op    <= OP_LSL;
      r_count <= '0;
      r_out   <= '0;
      r_sout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
      r_count <= w_count_nxt;
      r_out   <= w_out_nxt;
      r_sout  <= w_sout_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  // Next-state and datapath update
  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_count_nxt = r_count;
    w_out_nxt   = r_out;
    w_sout_nxt  = r_sout;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_LOAD: begin
              w_out_nxt   = load_data;
              w_state_nxt = S_DONE;
            end
            OP_LSL, OP_LSR, OP_ROL, OP_ROR, OP_ASR: begin
              if (amt != '0) begin
                w_op_nxt    = op;
                w_count_nxt = amt;
                w_state_nxt = S_RUN;
              end else begin
                w_state_nxt = S_DONE;
              end
            end
            default: w_state_nxt = S_DONE;
          endcase
        end
      end

      S_RUN: begin
        case (r_op)
          OP_LSL: begin
            w_out_nxt  = {r_out[WIDTH-2:0], in};
            w_sout_nxt = r_out[WIDTH-1];
          end
          OP_LSR: begin
            w_out_nxt  = {in, r_out[WIDTH-1:1]};
            w_sout_nxt = r_out[0];
          end
          OP_ROL: begin
            w_out_nxt  = {r_out[WIDTH-2:0], r_out[WIDTH-1]};
            w_sout_nxt = r_out[WIDTH-1];
          end
          OP_ROR: begin
            w_out_nxt  = {r_out[0], r_out[WIDTH-1:1]};
            w_sout_nxt = r_out[0];
          end
          OP_ASR: begin
            w_out_nxt  = {r_out[WIDTH-1], r_out[WIDTH-1:1]};
            w_sout_nxt = r_out[0];
          end
          default: begin
            w_out_nxt  = r_out;
            w_sout_nxt = r_sout;
          end
        endcase
        w_count_nxt = r_count - AMT_W'(1);
        if (r_count == AMT_W'(1)) begin
          w_state_nxt = S_DONE;
        end
      end

      S_DONE: w_state_nxt = S_IDLE;

      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign out  = r_out;
  assign sout = r_sout;
  assign busy = r_busy;
  assign done = r_done;

endmodule
